axis_cpu_farm_sched: RTL and testbench

//  Packet scheduler placed between one AXIS packet stream and NUM_CPUS axis_cpu cores.

---
 rtl/axis_cpu_farm_sched.sv | 158 +++++++++++++++
 tb/tb_axis_cpu_farm_sched.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_cpu_farm_sched.sv
// Round-robin packet scheduler for a farm of AXIS cores. Whole packets go to enabled cores,
// and a tag FIFO of core indices returns the results in dispatch order.
module axis_cpu_farm_sched #(
  parameter int NUM_CPUS   = 4,
  parameter int DATA_WIDTH = 32,
  parameter int TAG_DEPTH  = 8,
  parameter int CORE_W     = $clog2(NUM_CPUS)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_CPUS-1:0]              core_en,
  input  logic [DATA_WIDTH-1:0]            din_TDATA,
  input  logic                             din_TVALID,
  output logic                             din_TREADY,
  input  logic                             din_TLAST,
  output logic [NUM_CPUS*DATA_WIDTH-1:0]   core_din_TDATA,
  output logic [NUM_CPUS-1:0]              core_din_TVALID,
  input  logic [NUM_CPUS-1:0]              core_din_TREADY,
  output logic [NUM_CPUS-1:0]              core_din_TLAST,
  input  logic [NUM_CPUS*DATA_WIDTH-1:0]   core_dout_TDATA,
  input  logic [NUM_CPUS-1:0]              core_dout_TVALID,
  output logic [NUM_CPUS-1:0]              core_dout_TREADY,
  input  logic [NUM_CPUS-1:0]              core_dout_TLAST,
  output logic [DATA_WIDTH-1:0]            dout_TDATA,
  output logic                             dout_TVALID,
  input  logic                             dout_TREADY,
  output logic                             dout_TLAST,
  output logic [$clog2(TAG_DEPTH+1)-1:0]   in_flight
);

  localparam int AW = $clog2(TAG_DEPTH);
  localparam int CW = $clog2(TAG_DEPTH+1);

  typedef enum logic [0:0] {D_SEL = 1'b0, D_PKT = 1'b1} disp_state_t;

  disp_state_t       state_r;
  logic [CORE_W-1:0] rr_ptr_r;
  logic [CORE_W-1:0] sel_r;
  logic [CORE_W-1:0] pick_s;
  logic [CORE_W-1:0] head_s;
  logic [CORE_W:0]   idx_s;
  logic              found_s;
  logic [CORE_W-1:0] tag_mem_r [TAG_DEPTH];
  logic [AW-1:0]     wr_ptr_r;
  logic [AW-1:0]     rd_ptr_r;
  logic [CW-1:0]     count_r;
  logic              full_s;
  logic              empty_s;
  logic              push_s;
  logic              pop_s;
  logic              last_in_s;

  assign full_s    = (count_r == CW'(TAG_DEPTH));
  assign empty_s   = (count_r == {CW{1'b0}});
  assign push_s    = (state_r == D_SEL) && din_TVALID && !full_s && (|core_en);
  assign last_in_s = (state_r == D_PKT) && din_TVALID && din_TREADY && din_TLAST;
  assign pop_s     = !empty_s && dout_TVALID && dout_TREADY && dout_TLAST;
  assign head_s    = tag_mem_r[rd_ptr_r];
  assign in_flight = count_r;

  assign core_din_TDATA = {NUM_CPUS{din_TDATA}};
  assign core_din_TLAST = {NUM_CPUS{din_TLAST}};
  assign din_TREADY     = (state_r == D_PKT) ? core_din_TREADY[sel_r] : 1'b0;

  // First enabled core at or after the round-robin pointer, wrapping mod NUM_CPUS
  always_comb begin
    pick_s  = rr_ptr_r;
    found_s = 1'b0;
    idx_s   = {(CORE_W+1){1'b0}};
    for (int k = 0; k < NUM_CPUS; k++) begin
      idx_s   = {1'b0, rr_ptr_r} + (CORE_W+1)'(k);
      idx_s   = (idx_s >= (CORE_W+1)'(NUM_CPUS)) ? idx_s - (CORE_W+1)'(NUM_CPUS) : idx_s;
      pick_s  = (!found_s && core_en[idx_s[CORE_W-1:0]]) ? idx_s[CORE_W-1:0] : pick_s;
      found_s = found_s | core_en[idx_s[CORE_W-1:0]];
    end
  end

  // Only the selected core sees a valid beat while a packet is in progress
  always_comb begin
    core_din_TVALID = {NUM_CPUS{1'b0}};
    for (int i = 0; i < NUM_CPUS; i++) begin
      if ((state_r == D_PKT) && (sel_r == CORE_W'(i))) begin
        core_din_TVALID[i] = din_TVALID;
      end else begin
        core_din_TVALID[i] = 1'b0;
      end
    end
  end

  // Dispatcher FSM: pick a core and tag it, then stream the packet to it
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r  <= D_SEL;
      rr_ptr_r <= {CORE_W{1'b0}};
      sel_r    <= {CORE_W{1'b0}};
    end else begin
      case (state_r)
        D_SEL: begin
          if (push_s) begin
            sel_r   <= pick_s;
            state_r <= D_PKT;
          end
        end
        D_PKT: begin
          if (last_in_s) begin
            rr_ptr_r <= (sel_r == CORE_W'(NUM_CPUS-1)) ? {CORE_W{1'b0}} : sel_r + CORE_W'(1);
            state_r  <= D_SEL;
          end
        end
        default: state_r <= D_SEL;
      endcase
    end
  end

  // Tag FIFO of dispatched core indices
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
      for (int t = 0; t < TAG_DEPTH; t++) begin
        tag_mem_r[t] <= {CORE_W{1'b0}};
      end
    end else begin
      if (push_s) begin
        tag_mem_r[wr_ptr_r] <= pick_s;
        wr_ptr_r            <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Collector: forward the core named by the oldest tag, hold all others off
  always_comb begin
    dout_TDATA       = {DATA_WIDTH{1'b0}};
    dout_TVALID      = 1'b0;
    dout_TLAST       = 1'b0;
    core_dout_TREADY = {NUM_CPUS{1'b0}};
    for (int i = 0; i < NUM_CPUS; i++) begin
      if (!empty_s && (head_s == CORE_W'(i))) begin
        dout_TDATA          = core_dout_TDATA[i*DATA_WIDTH +: DATA_WIDTH];
        dout_TVALID         = core_dout_TVALID[i];
        dout_TLAST          = core_dout_TLAST[i];
        core_dout_TREADY[i] = dout_TREADY;
      end else begin
        core_dout_TREADY[i] = 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_axis_cpu_farm_sched.sv
// Bench for axis_cpu_farm_sched: behavioural cores echo packets with random latency;
// a round-robin reference model predicts the target core and the output beat order.
module tb_axis_cpu_farm_sched;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int TD = 2;

  logic               clk = 1'b0;
  logic               rst;
  logic [N-1:0]       core_en;
  logic [DW-1:0]      din_TDATA;
  logic               din_TVALID;
  logic               din_TREADY;
  logic               din_TLAST;
  logic [N*DW-1:0]    core_din_TDATA;
  logic [N-1:0]       core_din_TVALID;
  logic [N-1:0]       core_din_TREADY;
  logic [N-1:0]       core_din_TLAST;
  logic [N*DW-1:0]    core_dout_TDATA;
  logic [N-1:0]       core_dout_TVALID;
  logic [N-1:0]       core_dout_TREADY;
  logic [N-1:0]       core_dout_TLAST;
  logic [DW-1:0]      dout_TDATA;
  logic               dout_TVALID;
  logic               dout_TREADY;
  logic               dout_TLAST;
  logic [1:0]         in_flight;

  axis_cpu_farm_sched #(.NUM_CPUS(N), .DATA_WIDTH(DW), .TAG_DEPTH(TD)) dut (
    .clk(clk), .rst(rst), .core_en(core_en),
    .din_TDATA(din_TDATA), .din_TVALID(din_TVALID), .din_TREADY(din_TREADY), .din_TLAST(din_TLAST),
    .core_din_TDATA(core_din_TDATA), .core_din_TVALID(core_din_TVALID),
    .core_din_TREADY(core_din_TREADY), .core_din_TLAST(core_din_TLAST),
    .core_dout_TDATA(core_dout_TDATA), .core_dout_TVALID(core_dout_TVALID),
    .core_dout_TREADY(core_dout_TREADY), .core_dout_TLAST(core_dout_TLAST),
    .dout_TDATA(dout_TDATA), .dout_TVALID(dout_TVALID), .dout_TREADY(dout_TREADY),
    .dout_TLAST(dout_TLAST), .in_flight(in_flight)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // core models and reference state
  logic [DW:0] cbuf [N][64];
  int          wp [N];
  int          rp [N];
  bit          taken [N];
  bit          hold [N];
  int          rdy_mode;
  logic [DW:0] exp_q [$];
  int          hist [$];
  int          pkts_in, pkts_out, rr_m, exp_core;
  bit          pkt_act;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input int rr, input logic [N-1:0] en);
    for (int k = 0; k < N; k++) begin
      if (en[(rr + k) % N]) return (rr + k) % N;
    end
    return -1;
  endfunction

  function automatic int onehot_idx(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  // monitor: records handshakes at the falling edge, checks dispatch and output order
  initial begin
    for (int i = 0; i < N; i++) begin wp[i] = 0; rp[i] = 0; taken[i] = 1'b0; end
    pkts_in = 0; pkts_out = 0; rr_m = 0; pkt_act = 1'b0; exp_core = 0;
    forever begin
      @(negedge clk);
      if (rst !== 1'b1) begin
        for (int i = 0; i < N; i++) begin rp[i] = wp[i]; taken[i] = 1'b0; end
        exp_q.delete();
        pkt_act = 1'b0; rr_m = 0; pkts_in = 0; pkts_out = 0;
      end else begin
        for (int i = 0; i < N; i++) begin
          taken[i] = core_dout_TVALID[i] && core_dout_TREADY[i];
          if (taken[i]) rp[i]++;
          if (core_din_TVALID[i] && core_din_TREADY[i]) begin
            cbuf[i][wp[i] % 64] = {core_din_TLAST[i], core_din_TDATA[i*DW +: DW]};
            wp[i]++;
          end
        end
        if (din_TVALID && din_TREADY) begin
          if (!pkt_act) begin
            exp_core = pick(rr_m, core_en);
            pkt_act  = 1'b1;
            hist.push_back(onehot_idx(core_din_TVALID));
          end
          chk("dispatch_core", 64'(core_din_TVALID), 64'(4'b0001 << exp_core));
          exp_q.push_back({din_TLAST, din_TDATA});
          if (din_TLAST) begin
            pkt_act = 1'b0;
            rr_m    = (exp_core + 1) % N;
            pkts_in++;
          end
        end
        if (dout_TVALID && dout_TREADY) begin
          if (exp_q.size() == 0) chk("dout_unexpected", 64'd1, 64'd0);
          else chk("dout_beat", 64'({dout_TLAST, dout_TDATA}), 64'(exp_q.pop_front()));
          if (dout_TLAST) pkts_out++;
        end
      end
    end
  end

  // core and sink drivers, updated just after the rising edge
  initial begin
    core_din_TREADY = '0; core_dout_TVALID = '0; core_dout_TDATA = '0; core_dout_TLAST = '0;
    dout_TREADY = 1'b0;
    forever begin
      @(posedge clk); #1;
      for (int i = 0; i < N; i++) begin
        core_din_TREADY[i] = ($urandom_range(0, 3) != 0);
        if (!(core_dout_TVALID[i] && !taken[i] && rp[i] < wp[i])) begin
          core_dout_TVALID[i] = !hold[i] && (rp[i] < wp[i]) && ($urandom_range(0, 3) != 0);
        end
        {core_dout_TLAST[i], core_dout_TDATA[i*DW +: DW]} = cbuf[i][rp[i] % 64];
      end
      dout_TREADY = (rdy_mode == 1) ? 1'b1 : (rdy_mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
    end
  end

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic beat(input logic last);
    int n;
    bit hs;
    din_TDATA = $urandom; din_TLAST = last; din_TVALID = 1'b1;
    n = 0; hs = 1'b0;
    while (!hs && n < 300) begin
      @(negedge clk); hs = din_TREADY;
      tick(); n++;
    end
    if (!hs) chk("send_timeout", 64'd0, 64'd1);
  endtask

  task automatic send_pkt(input int len, input logic [N-1:0] mid_en, input bit chg);
    for (int b = 0; b < len; b++) begin
      beat(b == len - 1);
      if (b == 0 && chg) core_en = mid_en;
    end
    din_TVALID = 1'b0; din_TLAST = 1'b0;
  endtask

  task automatic drain;
    int n;
    n = 0;
    while ((pkts_out != pkts_in || in_flight != 2'd0) && n < 1000) begin tick(); n++; end
    chk("drain_timeout", 64'(n < 1000), 64'd1);
  endtask

  task automatic do_reset;
    rst = 1'b0; din_TVALID = 1'b0; din_TLAST = 1'b0;
    tick(); tick();
    rst = 1'b1;
  endtask

  initial begin
    int h0;
    rst = 1'b0; core_en = 4'hF; din_TDATA = '0; din_TVALID = 1'b0; din_TLAST = 1'b0;
    rdy_mode = 1;
    for (int i = 0; i < N; i++) hold[i] = 1'b0;
    tick();

    // reset state
    do_reset();
    @(negedge clk);
    chk("rst_din_ready", 64'(din_TREADY), 64'd0);
    chk("rst_core_din_valid", 64'(core_din_TVALID), 64'd0);
    chk("rst_core_dout_ready", 64'(core_dout_TREADY), 64'd0);
    chk("rst_dout_valid", 64'(dout_TVALID), 64'd0);
    chk("rst_in_flight", 64'(in_flight), 64'd0);
    tick();

    // three single-beat packets, then a fourth shows the pointer reached core 3
    h0 = hist.size();
    for (int p = 0; p < 4; p++) send_pkt(1, 4'h0, 1'b0);
    drain();
    for (int p = 0; p < 4; p++) chk("t1_core", 64'(hist[h0 + p]), 64'(p));
    chk("t1_count", 64'(pkts_out), 64'd4);

    // core 1 finishes first, output must still wait for core 0
    do_reset();
    hold[0] = 1'b1;
    h0 = hist.size();
    send_pkt(1, 4'h0, 1'b0);
    send_pkt(1, 4'h0, 1'b0);
    repeat (6) tick();
    @(negedge clk);
    chk("t2_dout_valid_held", 64'(dout_TVALID), 64'd0);
    chk("t2_core1_not_ready", 64'(core_dout_TREADY[1]), 64'd0);
    chk("t2_in_flight", 64'(in_flight), 64'd2);
    chk("t2_nothing_out", 64'(pkts_out), 64'd0);
    tick();
    hold[0] = 1'b0;
    drain();
    chk("t2_core_a", 64'(hist[h0]), 64'd0);
    chk("t2_core_b", 64'(hist[h0 + 1]), 64'd1);
    chk("t2_count", 64'(pkts_out), 64'd2);

    // sparse enable mask, core 1 disabled mid-packet
    do_reset();
    core_en = 4'b1010;
    h0 = hist.size();
    send_pkt(3, 4'b1000, 1'b1);
    send_pkt(2, 4'h0, 1'b0);
    core_en = 4'b1010;
    send_pkt(1, 4'h0, 1'b0);
    drain();
    chk("t3_core_p1", 64'(hist[h0]), 64'd1);
    chk("t3_core_p2", 64'(hist[h0 + 1]), 64'd3);
    chk("t3_core_p3", 64'(hist[h0 + 2]), 64'd1);

    // tag FIFO full stalls the third packet until the first pop
    do_reset();
    core_en = 4'hF; rdy_mode = 0;
    send_pkt(1, 4'h0, 1'b0);
    send_pkt(1, 4'h0, 1'b0);
    din_TDATA = $urandom; din_TLAST = 1'b1; din_TVALID = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("t4_stall_ready", 64'(din_TREADY), 64'd0);
      chk("t4_in_flight", 64'(in_flight), 64'd2);
      tick();
    end
    rdy_mode = 1;
    send_pkt(1, 4'h0, 1'b0);
    drain();
    chk("t4_count", 64'(pkts_out), 64'd3);

    // no enabled core: nothing accepted, nothing tagged
    do_reset();
    core_en = 4'h0;
    din_TDATA = $urandom; din_TLAST = 1'b1; din_TVALID = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("t5_ready", 64'(din_TREADY), 64'd0);
      chk("t5_in_flight", 64'(in_flight), 64'd0);
      chk("t5_core_valid", 64'(core_din_TVALID), 64'd0);
      tick();
    end
    din_TVALID = 1'b0; din_TLAST = 1'b0;
    tick();
    core_en = 4'hF;

    // reset during the second beat of a packet on core 2
    do_reset();
    send_pkt(1, 4'h0, 1'b0);
    send_pkt(1, 4'h0, 1'b0);
    drain();
    beat(1'b0);
    chk("t6_trunc_core", 64'(hist[hist.size() - 1]), 64'd2);
    din_TDATA = $urandom; din_TLAST = 1'b0; din_TVALID = 1'b1;
    rst = 1'b0;
    tick();
    rst = 1'b1; din_TVALID = 1'b0;
    @(negedge clk);
    chk("t6_din_ready", 64'(din_TREADY), 64'd0);
    chk("t6_core_din_valid", 64'(core_din_TVALID), 64'd0);
    chk("t6_core_dout_ready", 64'(core_dout_TREADY), 64'd0);
    chk("t6_dout_valid", 64'(dout_TVALID), 64'd0);
    chk("t6_in_flight", 64'(in_flight), 64'd0);
    tick();
    send_pkt(2, 4'h0, 1'b0);
    drain();
    chk("t6_next_core", 64'(hist[hist.size() - 1]), 64'd0);

    // randomized traffic with random masks, lengths and backpressure
    do_reset();
    rdy_mode = 2;
    for (int p = 0; p < 40; p++) begin
      if ($urandom_range(0, 3) == 0) core_en = 4'($urandom_range(1, 15));
      send_pkt($urandom_range(1, 4), 4'h0, 1'b0);
      repeat ($urandom_range(0, 2)) tick();
    end
    drain();
    chk("rand_count", 64'(pkts_out), 64'd40);
    chk("rand_leftover", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
